// File: rtl/result_unloader_if.sv
// Block-in / word-out handshake bundle for the result unloader.
// The slave side is the unloader; the master side feeds blocks and sinks words.
interface result_unloader_if #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 8
);
    logic                      blk_valid_i;
    logic [WORD_W*WORDS-1:0]   blk_data_i;
    logic                      blk_ready_o;
    logic                      result_ready_i;
    logic                      result_valid_o;
    logic [WORD_W-1:0]         result_payload_o;
    logic                      result_last_o;
    logic                      busy_o;

    modport slave (
        input  blk_valid_i,
        input  blk_data_i,
        input  result_ready_i,
        output blk_ready_o,
        output result_valid_o,
        output result_payload_o,
        output result_last_o,
        output busy_o
    );

    modport master (
        output blk_valid_i,
        output blk_data_i,
        output result_ready_i,
        input  blk_ready_o,
        input  result_valid_o,
        input  result_payload_o,
        input  result_last_o,
        input  busy_o
    );
endinterface

// File: rtl/result_unloader.sv
// Two-slot block buffer that streams each 256-bit result block
// out as WORDS words, most significant word first.
module result_unloader #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 8,
    parameter int DEPTH  = 2
) (
    input logic              clk_pe,
    input logic              rst_n,
    result_unloader_if.slave bus
);
    localparam int BLK_W = WORD_W * WORDS;
    localparam int WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [1:0]      FULL      = 2'(DEPTH);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS - 1);

    logic [BLK_W-1:0]  slot [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [WC_W-1:0]   word_cnt;
    logic [0:0]        state;
    logic              valid;
    logic              accept;
    logic              xfer;
    logic              rel;
    logic [WORD_W-1:0] words [WORDS];

    always_comb state = (count != 2'd0) ? ST_SEND : ST_IDLE;

    assign valid  = rst_n && (state == ST_SEND);
    assign accept = bus.blk_valid_i && bus.blk_ready_o;
    assign xfer   = valid && bus.result_ready_i;
    assign rel    = xfer && (word_cnt == LAST_WORD);

    // Word 0 is the top slice of the block.
    always_comb begin
        for (int k = 0; k < WORDS; k++) begin
            words[k] = slot[rd_ptr][WORD_W*(WORDS-1-k) +: WORD_W];
        end
    end

    assign bus.blk_ready_o      = rst_n && (count != FULL);
    assign bus.result_valid_o   = valid;
    assign bus.result_payload_o = rst_n ? words[word_cnt] : '0;
    assign bus.result_last_o    = valid && (word_cnt == LAST_WORD);
    assign bus.busy_o           = valid;

    always_ff @(posedge clk_pe) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            word_cnt <= '0;
            for (int i = 0; i < 2; i++) begin
                slot[i] <= '0;
            end
        end else begin
            if (accept) begin
                slot[wr_ptr] <= bus.blk_data_i;
                wr_ptr       <= ~wr_ptr;
            end
            if (xfer) begin
                if (rel) begin
                    word_cnt <= '0;
                    rd_ptr   <= ~rd_ptr;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
            case ({accept, rel})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_result_unloader.sv
// Randomised scoreboard bench for result_unloader.
// Expected words are queued on block accept and popped on word transfer.
module tb_result_unloader;
    typedef struct {
        logic [31:0] w;
        logic        l;
    } exp_t;

    logic clk_pe = 1'b0;
    logic rst_n  = 1'b0;
    logic rand_rdy = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    exp_t q [$];

    result_unloader_if bus ();

    result_unloader dut (
        .clk_pe (clk_pe),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_pe = ~clk_pe;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Tracker: a block seen offered and ready before an edge
    // is accepted at that edge; queue its words MSB first.
    initial begin
        logic         a;
        logic [255:0] d;
        forever begin
            @(negedge clk_pe);
            a = rst_n && bus.blk_valid_i && bus.blk_ready_o;
            d = bus.blk_data_i;
            @(posedge clk_pe);
            if (a) begin
                for (int k = 0; k < 8; k++) begin
                    exp_t e;
                    e.w = d[32*(7-k) +: 32];
                    e.l = (k == 7);
                    q.push_back(e);
                end
            end
        end
    end

    // Monitor: compare presented outputs with the model state.
    always @(negedge clk_pe) begin
        logic ev;
        int   blocks;
        if (!rst_n) begin
            chk("rst_valid", 32'(bus.result_valid_o), 32'd0);
            chk("rst_last", 32'(bus.result_last_o), 32'd0);
            chk("rst_busy", 32'(bus.busy_o), 32'd0);
            chk("rst_ready", 32'(bus.blk_ready_o), 32'd0);
            chk("rst_payload", bus.result_payload_o, 32'd0);
            q.delete();
        end else begin
            ev     = (q.size() != 0);
            blocks = (q.size() + 7) / 8;
            chk("valid", 32'(bus.result_valid_o), 32'(ev));
            chk("busy", 32'(bus.busy_o), 32'(ev));
            chk("blk_ready", 32'(bus.blk_ready_o),
                32'(blocks < 2));
            if (ev) begin
                chk("payload", bus.result_payload_o, q[0].w);
                chk("last", 32'(bus.result_last_o), 32'(q[0].l));
            end else begin
                chk("last_idle", 32'(bus.result_last_o), 32'd0);
            end
            if (bus.result_valid_o && bus.result_ready_i && ev) begin
                void'(q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_pe);
            #1;
            if (rand_rdy) begin
                bus.result_ready_i = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk_pe);
        #1;
    endtask

    task automatic send_block(input logic [255:0] d);
        int   n;
        logic took;
        n = 0;
        took = 1'b0;
        bus.blk_valid_i = 1'b1;
        bus.blk_data_i  = d;
        while (!took && n < 300) begin
            @(negedge clk_pe);
            took = bus.blk_ready_o;
            tick();
            n++;
        end
        if (!took) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
        bus.blk_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk_pe);
            n++;
        end while (bus.busy_o && n < 1000);
        if (bus.busy_o) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got busy expected idle");
        end
        tick();
    endtask

    function automatic logic [255:0] rand_blk();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) begin
            d[32*k +: 32] = $urandom();
        end
        return d;
    endfunction

    initial begin
        logic [255:0] d;

        bus.blk_valid_i    = 1'b1;
        bus.blk_data_i     = rand_blk();
        bus.result_ready_i = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk_pe);
        #1;
        rst_n = 1'b1;
        bus.blk_valid_i = 1'b0;
        tick();

        // Single block of words 7..0, counted from the top.
        for (int k = 0; k < 8; k++) begin
            d[32*k +: 32] = 32'(k);
        end
        send_block(d);
        wait_idle();

        // Three blocks back to back.
        for (int b = 0; b < 3; b++) begin
            send_block(rand_blk());
        end
        wait_idle();

        // Stall pattern 1,0,0,1 mid-block.
        send_block(rand_blk());
        tick();
        tick();
        bus.result_ready_i = 1'b0;
        tick();
        tick();
        bus.result_ready_i = 1'b1;
        wait_idle();

        // New block accepted on the edge its predecessor ends.
        send_block(rand_blk());
        repeat (7) tick();
        send_block(rand_blk());
        wait_idle();

        // Reset after word 3 has transferred.
        send_block(rand_blk());
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_block(rand_blk());
        wait_idle();

        // Random traffic with random downstream backpressure.
        rand_rdy = 1'b1;
        for (int b = 0; b < 40; b++) begin
            send_block(rand_blk());
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_rdy = 1'b0;
        bus.result_ready_i = 1'b1;
        wait_idle();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/result_unloader.md
# result_unloader

Output-side serializer for the MulAdd accelerator. It accepts 256-bit result blocks from the PE datapath through a valid/ready handshake, buffers up to two blocks, and streams each block out as eight 32-bit words on the `result_valid_o`/`result_payload_o` interface. It is the transmit counterpart of the input shift buffer, which packs eight 32-bit load words into one 256-bit vector. It runs on a single clock.

## Interface
- `WORD_W`, default 32: output word width.
- `WORDS`, default 8: words per block; block width is `WORD_W*WORDS`, 256 bits by default.
- `DEPTH`, default 2: block buffer entries; fixed at 2 for this revision.

Ports:
- `clk_pe`  in  1  the only clock.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk_pe`.
- `blk_valid_i`  in  1  a result block is offered on `blk_data_i`.
- `blk_data_i`  in  256  result block.
- `blk_ready_o`  out  1  buffer can accept a block this cycle.
- `result_ready_i`  in  1  downstream accepts the current word.
- `result_valid_o`  out  1  `result_payload_o` holds a valid word.
- `result_payload_o`  out  32  current output word.
- `result_last_o`  out  1  current word is word `WORDS-1` of its block.
- `busy_o`  out  1  at least one block is buffered or draining.

## Operation
- **Storage.** Two block slots form a circular FIFO.
  - Registers: `wr_ptr` (1 bit), `rd_ptr` (1 bit), `count` (0..2) and `word_cnt` (3 bits, 0..`WORDS-1`).
- **Block accept.** A block is accepted when `blk_valid_i && blk_ready_o`.
  - The block is written to `slot[wr_ptr]` and `wr_ptr` toggles.
  - `blk_ready_o = (count != 2)`. It is a combinational function of registered state only and does not depend on `blk_valid_i`.
- **Word order.** Word k of a block is `blk_data[WORD_W*(WORDS-1-k) +: WORD_W]`. The MSB word is sent first, mirroring the left-shifting input packer.
- **Output drive.**
  - `result_valid_o = (count != 0)`.
  - `result_payload_o = slot[rd_ptr]` word `word_cnt`.
  - `result_last_o = result_valid_o && (word_cnt == WORDS-1)`.
  - `busy_o = (count != 0)`.
- **Word transfer.** A word transfers when `result_valid_o && result_ready_i`.
  - `word_cnt` increments.
  - On the last word, `word_cnt` wraps to 0, `rd_ptr` toggles and the block is released.
- **Hold under stall.** While `result_ready_i` = 0, payload, `result_last_o` and `word_cnt` hold.
- **Count update.** `count` += accept − release. A simultaneous accept and release leaves `count` unchanged.
- **States.** The FSM state is implied by `count`:
  - IDLE (`count` = 0) → SEND (`count` ≥ 1) on accept.
  - SEND → IDLE on release with no simultaneous accept and `count` = 1.
  - SEND → SEND otherwise.
- **No overflow by construction.** A block offered while `count` = 2 is not accepted. The sender must hold it.

## Timing
- **Reset** (`rst_n` = 0 at an edge): after that edge, `count`, pointers and `word_cnt` are 0.
  - Outputs: `result_valid_o` = 0, `result_last_o` = 0, `busy_o` = 0, `result_payload_o` = 0, `blk_ready_o` = 0 while `rst_n` is low.
  - Slot contents are cleared to 0.
- **Reset mid-block** discards all buffered data. The first cycle after reset release has `blk_ready_o` = 1 and `result_valid_o` = 0.
- **Latency.** A block accepted at edge N produces word 0 with `result_valid_o` = 1 in the cycle after edge N.
- **Throughput.** One word per cycle when `result_ready_i` = 1.
  - A block occupies exactly `WORDS` transfer cycles.
  - Back-to-back buffered blocks stream with no bubble: word 7 of block A is followed immediately by word 0 of block B.
- **Full-buffer accept.** With `count` = 2, `blk_ready_o` = 0 for the whole cycle, including the cycle in which the last word of the head block transfers.
  - `blk_ready_o` returns to 1 in the following cycle.
  - There is no same-cycle fall-through.
- **Empty buffer.** `result_valid_o` deasserts in the cycle after the final word transfers if nothing is buffered.

## Test plan
- **Reset values.** Hold `rst_n` low 3 cycles with `blk_valid_i` = 1 → all outputs 0 and nothing accepted. After release, `blk_ready_o` = 1 and `result_valid_o` = 0.
- **Single block.** Send `blk_data_i` = {32'h0000_0007, …, 32'h0000_0000}, MSB word first, with `result_ready_i` = 1 → words 7,6,…,0 on 8 consecutive cycles starting the cycle after accept. `result_last_o` is high only on word 0, then `result_valid_o` = 0.
- **Back-to-back blocks.** Offer 3 blocks back-to-back → `blk_ready_o` drops after 2 accepts, and the third is accepted the cycle after the last word of block 1. All 24 words are contiguous with no gap.
- **Downstream stall.** Toggle `result_ready_i` in the pattern 1,0,0,1 mid-block → payload holds during the stall, and no word is duplicated or dropped in the scoreboard.
- **Simultaneous accept and release.** With `count` = 1, accept a new block in the same cycle the last word transfers → `count` stays 1 and the next word is word 0 of the new block.
- **Reset mid-block.** Assert `rst_n` = 0 after word 3 → outputs clear at the next edge. A fresh block after release starts at its word 0.
